// File: rtl/sdram_init_aref_ctrl.sv
// Command-only SDR SDRAM controller (MT48LC2M32B2 class, 11-bit row, 4 banks).
// Runs the power-up sequence (NOP wait, PRECHARGE ALL, INIT_REF_CNT AUTO REFRESH,
// LOAD MODE) and then issues periodic AUTO REFRESH forever. There is no data path.
//
// Ports:
//   clk       system clock (100 MHz)
//   rst_n     synchronous active-low reset
//   sdr_ck    SDRAM clock, inverted clk so the device samples mid-cycle
//   sdr_cke   clock enable, high from the first clock after reset release
//   sdr_csn, sdr_rasn, sdr_casn, sdr_wen   registered command pins
//   sdr_addr  address (A10 = all banks for PRECHARGE, mode word for LOAD MODE)
//   sdr_ba    bank address (always 0 for the commands issued here)
//
// Optional build macro SDRAM_REF_PRECHARGE_EN: each periodic refresh is preceded
// by a PRECHARGE ALL, with AUTO REFRESH T_RP cycles later.

module sdram_init_aref_ctrl #(
  parameter int unsigned T_POWERUP    = 20000,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned T_RFC        = 7,
  parameter int unsigned T_MRD        = 2,
  parameter int unsigned INIT_REF_CNT = 8,
  parameter int unsigned REF_INTERVAL = 1500,
  parameter logic [10:0] MODE_REG     = 11'h030
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        sdr_ck,
  output logic        sdr_cke,
  output logic        sdr_csn,
  output logic        sdr_rasn,
  output logic        sdr_casn,
  output logic        sdr_wen,
  output logic [10:0] sdr_addr,
  output logic [1:0]  sdr_ba
);

  localparam int unsigned CntW = ($clog2(T_POWERUP + 1) > 15) ? $clog2(T_POWERUP + 1) : 15;
  localparam int unsigned TmrW = ($clog2(REF_INTERVAL) > 11) ? $clog2(REF_INTERVAL) : 11;
  localparam int unsigned RefW = $clog2(INIT_REF_CNT + 1);

  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdAref = 4'b0001;
  localparam logic [3:0] CmdMrs  = 4'b0000;

  localparam logic [10:0] AddrPreAll = 11'h400;

  typedef enum logic [3:0] {
    StWait,
    StPre,
    StTrp,
    StAref,
    StTrfc,
    StMrs,
    StTmrd,
    StIdle,
    StRef,
    StRefTrfc,
    StRefPre,
    StRefTrp
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              run_q, run_d;
  logic              req_q, req_d;
  logic              tmr_run, tmr_hit, service;

  logic              cke_q;
  logic [3:0]        cmd_q, cmd_d;
  logic [10:0]       addr_q, addr_d;
  logic [1:0]        ba_q, ba_d;

  // The counter clears on every state change, so a wait state entered the cycle
  // after its command leaves when cnt reaches T-2: command-to-command is exactly T.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:    if (cnt_q == CntW'(T_POWERUP)) state_d = StPre;
      StPre:     state_d = StTrp;
      StTrp:     if (cnt_q == CntW'(T_RP - 2)) state_d = StAref;
      StAref:    state_d = StTrfc;
      StTrfc: begin
        if (cnt_q == CntW'(T_RFC - 2)) begin
          state_d = (ref_cnt_q < RefW'(INIT_REF_CNT)) ? StAref : StMrs;
        end
      end
      StMrs:     state_d = StTmrd;
      StTmrd:    if (cnt_q == CntW'(T_MRD - 2)) state_d = StIdle;
      StIdle: begin
        if (req_q || tmr_hit) begin
`ifdef SDRAM_REF_PRECHARGE_EN
          state_d = StRefPre;
`else
          state_d = StRef;
`endif
        end
      end
`ifdef SDRAM_REF_PRECHARGE_EN
      StRefPre:  state_d = StRefTrp;
      StRefTrp:  if (cnt_q == CntW'(T_RP - 2)) state_d = StRef;
`endif
      StRef:     state_d = StRefTrfc;
      StRefTrfc: if (cnt_q == CntW'(T_RFC - 2)) state_d = StIdle;
      default:   state_d = StWait;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == {CntW{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    ref_cnt_d = ref_cnt_q;
    if (state_q == StAref && ref_cnt_q != {RefW{1'b1}}) begin
      ref_cnt_d = ref_cnt_q + RefW'(1);
    end

    // Refresh timer runs from the LOAD MODE cycle onward.
    tmr_run = run_q || (state_q == StMrs);
    run_d   = tmr_run;
    tmr_hit = tmr_run && (tmr_q == TmrW'(REF_INTERVAL - 1));
    if (!tmr_run || tmr_hit) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TmrW'(1);
    end

    // A request raised outside IDLE stays pending until IDLE takes it.
    service = (state_q == StIdle) && (state_d != StIdle);
    req_d   = (req_q || tmr_hit) && !service;
  end

  // Pin values follow the state being entered so they line up with state_q.
  always_comb begin
    cmd_d  = CmdNop;
    addr_d = '0;
    ba_d   = '0;
    unique case (state_d)
      StPre, StRefPre: begin
        cmd_d  = CmdPre;
        addr_d = AddrPreAll;
      end
      StAref, StRef: cmd_d = CmdAref;
      StMrs: begin
        cmd_d  = CmdMrs;
        addr_d = MODE_REG;
      end
      default: cmd_d = CmdNop;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StWait;
      cnt_q     <= '0;
      ref_cnt_q <= '0;
      tmr_q     <= '0;
      run_q     <= 1'b0;
      req_q     <= 1'b0;
      cke_q     <= 1'b0;
      cmd_q     <= CmdNop;
      addr_q    <= '0;
      ba_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_cnt_q <= ref_cnt_d;
      tmr_q     <= tmr_d;
      run_q     <= run_d;
      req_q     <= req_d;
      cke_q     <= 1'b1;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ba_q      <= ba_d;
    end
  end

  assign sdr_ck   = ~clk;
  assign sdr_cke  = cke_q;
  assign sdr_csn  = cmd_q[3];
  assign sdr_rasn = cmd_q[2];
  assign sdr_casn = cmd_q[1];
  assign sdr_wen  = cmd_q[0];
  assign sdr_addr = addr_q;
  assign sdr_ba   = ba_q;

endmodule

// File: tb/tb_sdram_init_aref_ctrl.sv
module tb_sdram_init_aref_ctrl;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdr_ck, sdr_cke, sdr_csn, sdr_rasn, sdr_casn, sdr_wen;
  logic [10:0] sdr_addr;
  logic [1:0]  sdr_ba;
  logic [3:0]  cmd;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign cmd = {sdr_csn, sdr_rasn, sdr_casn, sdr_wen};

  always #5 clk = ~clk;

  sdram_init_aref_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sdr_ck   (sdr_ck),
    .sdr_cke  (sdr_cke),
    .sdr_csn  (sdr_csn),
    .sdr_rasn (sdr_rasn),
    .sdr_casn (sdr_casn),
    .sdr_wen  (sdr_wen),
    .sdr_addr (sdr_addr),
    .sdr_ba   (sdr_ba)
  );

  // Step negedge by negedge until a non-NOP command shows up or the bound expires.
  task automatic wait_cmd(input int max_cyc, output logic [3:0] c, output int dt);
    bit found;
    found = 1'b0;
    dt = 0;
    c = NOP;
    while (!found && dt < max_cyc) begin
      @(negedge clk);
      dt++;
      if (cmd !== NOP) begin
        c = cmd;
        found = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (sdr_cke !== 1'b0) $display("FAIL reset_cke got %b want 0", sdr_cke);
    else pass_cnt++;
    total_cnt++;
    if (cmd !== NOP) $display("FAIL reset_cmd got %b want %b", cmd, NOP);
    else pass_cnt++;
    total_cnt++;
    if (sdr_addr !== 11'h000 || sdr_ba !== 2'b00)
      $display("FAIL reset_addr got %h/%b want 000/00", sdr_addr, sdr_ba);
    else pass_cnt++;
    total_cnt++;
    if (sdr_ck !== 1'b1) $display("FAIL reset_ck_low got %b want 1", sdr_ck);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (sdr_ck !== 1'b0) $display("FAIL reset_ck_high got %b want 0", sdr_ck);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // Releases reset at a negedge and checks the whole init sequence up to LOAD MODE.
  task automatic run_init(input string tag);
    logic [3:0] c;
    int dt;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (sdr_cke !== 1'b1 || cmd !== NOP)
      $display("FAIL %s_cke_rise got cke=%b cmd=%b want 1/%b", tag, sdr_cke, cmd, NOP);
    else pass_cnt++;

    wait_cmd(20100, c, dt);
    total_cnt++;
    if (c !== PRE || dt !== 20000)
      $display("FAIL %s_first_pre got cmd=%b dt=%0d want %b/20000", tag, c, dt, PRE);
    else pass_cnt++;
    total_cnt++;
    if (sdr_addr !== 11'h400 || sdr_ba !== 2'b00 || sdr_cke !== 1'b1)
      $display("FAIL %s_pre_addr got %h/%b cke=%b want 400/00 cke=1", tag, sdr_addr, sdr_ba,
               sdr_cke);
    else pass_cnt++;

    wait_cmd(20, c, dt);
    total_cnt++;
    if (c !== AREF || dt !== 2)
      $display("FAIL %s_aref1 got cmd=%b dt=%0d want %b/2", tag, c, dt, AREF);
    else pass_cnt++;

    for (int i = 2; i <= 8; i++) begin
      wait_cmd(20, c, dt);
      total_cnt++;
      if (c !== AREF || dt !== 7 || sdr_addr !== 11'h000)
        $display("FAIL %s_aref%0d got cmd=%b dt=%0d addr=%h want %b/7/000", tag, i, c, dt,
                 sdr_addr, AREF);
      else pass_cnt++;
    end

    wait_cmd(20, c, dt);
    total_cnt++;
    if (c !== LMR || dt !== 7)
      $display("FAIL %s_lmr got cmd=%b dt=%0d want %b/7", tag, c, dt, LMR);
    else pass_cnt++;
    total_cnt++;
    if (sdr_addr !== 11'h030 || sdr_ba !== 2'b00)
      $display("FAIL %s_lmr_addr got %h/%b want 030/00", tag, sdr_addr, sdr_ba);
    else pass_cnt++;
  endtask

  // Starts in the LOAD MODE cycle; checks n periodic refreshes.
  task automatic test_periodic(input string tag, input int n);
    logic [3:0] c;
    int dt;
    int gap;
    gap = 1500;
    for (int i = 0; i < n; i++) begin
`ifdef SDRAM_REF_PRECHARGE_EN
      wait_cmd(1700, c, dt);
      total_cnt++;
      if (c !== PRE || dt !== gap || sdr_addr !== 11'h400)
        $display("FAIL %s_ref_pre%0d got cmd=%b dt=%0d addr=%h want %b/%0d/400", tag, i, c, dt,
                 sdr_addr, PRE, gap);
      else pass_cnt++;
      wait_cmd(20, c, dt);
      total_cnt++;
      if (c !== AREF || dt !== 2)
        $display("FAIL %s_ref_aref%0d got cmd=%b dt=%0d want %b/2", tag, i, c, dt, AREF);
      else pass_cnt++;
      gap = 1498;
`else
      wait_cmd(1700, c, dt);
      total_cnt++;
      if (c !== AREF || dt !== gap || sdr_addr !== 11'h000 || sdr_ba !== 2'b00)
        $display("FAIL %s_ref%0d got cmd=%b dt=%0d addr=%h want %b/%0d/000", tag, i, c, dt,
                 sdr_addr, AREF, gap);
      else pass_cnt++;
`endif
    end
  endtask

  // Called in the cycle of a periodic AUTO REFRESH.
  task automatic test_reset_mid_refresh();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (sdr_cke !== 1'b0 || cmd !== NOP || sdr_addr !== 11'h000 || sdr_ba !== 2'b00)
      $display("FAIL midref_reset got cke=%b cmd=%b addr=%h ba=%b want 0/%b/000/00", sdr_cke,
               cmd, sdr_addr, sdr_ba, NOP);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (sdr_cke !== 1'b0 || cmd !== NOP)
      $display("FAIL midref_hold got cke=%b cmd=%b want 0/%b", sdr_cke, cmd, NOP);
    else pass_cnt++;
    run_init("reinit");
    test_periodic("reinit", 1);
  endtask

  initial begin
    test_reset();
    run_init("init");
    test_periodic("per", 4);
    test_reset_mid_refresh();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
